// File: rtl/led_pio_ctrl_if.sv
// Avalon-MM slave bus bundle for the LED/PIO controller.
// Master drives address/strobes/writedata; slave returns combinational readdata.
interface led_pio_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_pio_ctrl.sv
// LED/PIO output controller: DATA with atomic set/clear, per-channel blink, global PWM.
// Register write visible on readdata after the edge; out_port one edge later. No backpressure.
module led_pio_ctrl #(
  parameter int               WIDTH       = 3,
  parameter int               DIV_W       = 24,
  parameter int               PWM_W       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  led_pio_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA     = 3'd0;
  localparam logic [2:0] A_MODE     = 3'd1;
  localparam logic [2:0] A_DIV      = 3'd2;
  localparam logic [2:0] A_DUTY     = 3'd3;
  localparam logic [2:0] A_OUTSET   = 3'd4;
  localparam logic [2:0] A_OUTCLEAR = 3'd5;
  localparam logic [2:0] A_STATUS   = 3'd6;

  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] mode_r;
  logic [DIV_W-1:0] div_r;
  logic [PWM_W-1:0] duty_r;
  logic [DIV_W-1:0] div_cnt;
  logic             blink_phase;
  logic [PWM_W-1:0] pwm_cnt;

  logic             wr;
  logic             pwm_on;
  logic [WIDTH-1:0] blink_mask;
  logic [31:0]      rd_dat;
  logic             unused_wd;

  assign wr         = bus.chipselect & ~bus.write_n;
  assign pwm_on     = (duty_r == '1) || (pwm_cnt < duty_r);
  // Blinking channels are gated off while the phase is low; steady channels pass.
  assign blink_mask = blink_phase ? '1 : ~mode_r;
  assign unused_wd  = ^bus.writedata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_r      <= RESET_VALUE;
      mode_r      <= '0;
      div_r       <= '0;
      duty_r      <= '1;
      div_cnt     <= '0;
      blink_phase <= 1'b1;
      pwm_cnt     <= '0;
      out_port    <= '0;
    end else begin
      out_port <= data_r & blink_mask & {WIDTH{pwm_on}};
      pwm_cnt  <= pwm_cnt + 1'b1;

      // Reprogramming the divider restarts the blink period in the on phase.
      if (wr && bus.address == A_DIV) begin
        div_cnt     <= '0;
        blink_phase <= 1'b1;
      end else if (div_cnt == div_r) begin
        div_cnt     <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (wr) begin
        case (bus.address)
          A_DATA:     data_r <= bus.writedata[WIDTH-1:0];
          A_MODE:     mode_r <= bus.writedata[WIDTH-1:0];
          A_DIV:      div_r  <= bus.writedata[DIV_W-1:0];
          A_DUTY:     duty_r <= bus.writedata[PWM_W-1:0];
          A_OUTSET:   data_r <= data_r | bus.writedata[WIDTH-1:0];
          A_OUTCLEAR: data_r <= data_r & ~bus.writedata[WIDTH-1:0];
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    case (bus.address)
      A_DATA:   rd_dat[WIDTH-1:0] = data_r;
      A_MODE:   rd_dat[WIDTH-1:0] = mode_r;
      A_DIV:    rd_dat[DIV_W-1:0] = div_r;
      A_DUTY:   rd_dat[PWM_W-1:0] = duty_r;
      A_STATUS: begin
        rd_dat[0]          = blink_phase;
        rd_dat[16 +: PWM_W] = pwm_cnt;
      end
      default:  rd_dat = '0;
    endcase
  end

  assign bus.readdata = rd_dat;

endmodule

// File: tb/tb_led_pio_ctrl.sv
// Self-checking bench for led_pio_ctrl: directed vector table, hand-written blink/PWM/reset
// sequences and a randomized run against a time-based behavioural model.
module tb_led_pio_ctrl;

  localparam int         WIDTH = 3;
  localparam int         DIV_W = 24;
  localparam int         PWM_W = 8;
  localparam logic [2:0] RV    = 3'h2;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] out_port;

  led_pio_ctrl_if bus ();

  led_pio_ctrl #(
    .WIDTH(WIDTH), .DIV_W(DIV_W), .PWM_W(PWM_W), .RESET_VALUE(RV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: register contents plus elapsed cycle counts; blink phase and pwm count
  // are derived arithmetically from time since the last anchor event.
  logic [2:0] m_data = RV;
  logic [2:0] m_mode = '0;
  int         m_div  = 0;
  int         m_duty = 255;
  int         m_anc  = 0;
  int         m_pwm  = 0;
  logic [2:0] m_out  = '0;

  function automatic bit m_phase();
    return ((m_anc / (m_div + 1)) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r[2:0] = m_data;
      3'd1: r[2:0] = m_mode;
      3'd2: r = 32'(m_div);
      3'd3: r = 32'(m_duty);
      3'd6: r = (32'(m_pwm % 256) << 16) | 32'(m_phase());
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit rst_n, input bit wr, input logic [2:0] a, input logic [31:0] wd);
    logic [2:0] nout;
    logic [2:0] mask;
    int         pc;
    bit         on;
    reset_n       = rst_n;
    bus.address   = a;
    bus.writedata = wd;
    if (wr) begin
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin bus.chipselect = 1'b0; bus.write_n = 1'b0; end
        1:       begin bus.chipselect = 1'b0; bus.write_n = 1'b1; end
        default: begin bus.chipselect = 1'b1; bus.write_n = 1'b1; end
      endcase
    end

    pc   = m_pwm % 256;
    on   = (m_duty == 255) || (pc < m_duty);
    mask = m_phase() ? 3'b111 : ~m_mode;
    nout = on ? (m_data & mask) : 3'b000;

    if (!rst_n) begin
      nout = 3'b000;
      m_data = RV; m_mode = '0; m_div = 0; m_duty = 255; m_anc = 0; m_pwm = 0;
    end else begin
      m_anc++;
      m_pwm++;
      if (wr) begin
        case (a)
          3'd0: m_data = wd[2:0];
          3'd1: m_mode = wd[2:0];
          3'd2: begin m_div = int'(wd[23:0]); m_anc = 0; end
          3'd3: m_duty = int'(wd[7:0]);
          3'd4: m_data = m_data | wd[2:0];
          3'd5: m_data = m_data & ~wd[2:0];
          default: ;
        endcase
      end
    end

    @(posedge clk);
    #1;
    m_out = nout;
    chk("model_out_port", 32'(out_port), 32'(m_out));
    chk("model_readdata", bus.readdata, m_read(a));
  endtask

  typedef struct {
    bit          rst_n;
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [2:0]  exp_out;
  } vec_t;

  vec_t vecs[$];
  int   cnt;
  logic [2:0]  ra;
  logic [31:0] rwd;

  initial begin
    reset_n        = 1'b0;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // rst_n, wr, addr, wd, expected readdata, expected out_port
    vecs.push_back('{0, 0, 3'd0, 32'h0, 32'h2,  3'b000});
    vecs.push_back('{0, 0, 3'd3, 32'h0, 32'hFF, 3'b000});
    vecs.push_back('{0, 0, 3'd6, 32'h0, 32'h1,  3'b000});
    vecs.push_back('{1, 0, 3'd0, 32'h0, 32'h2,  3'b010});
    vecs.push_back('{1, 1, 3'd0, 32'h5, 32'h5,  3'b010});
    vecs.push_back('{1, 0, 3'd0, 32'h0, 32'h5,  3'b101});
    vecs.push_back('{1, 1, 3'd4, 32'h2, 32'h0,  3'b101});
    vecs.push_back('{1, 0, 3'd0, 32'h0, 32'h7,  3'b111});
    vecs.push_back('{1, 1, 3'd5, 32'h4, 32'h0,  3'b111});
    vecs.push_back('{1, 0, 3'd0, 32'h0, 32'h3,  3'b011});
    vecs.push_back('{1, 1, 3'd7, 32'h7, 32'h0,  3'b011});
    vecs.push_back('{1, 0, 3'd0, 32'h0, 32'h3,  3'b011});
    vecs.push_back('{1, 0, 3'd1, 32'h0, 32'h0,  3'b011});
    vecs.push_back('{0, 1, 3'd0, 32'h7, 32'h2,  3'b000});
    vecs.push_back('{1, 0, 3'd0, 32'h0, 32'h2,  3'b010});

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].wr, vecs[i].addr, vecs[i].wd);
      chk($sformatf("vec%0d_readdata", i), bus.readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_out_port", i), 32'(out_port), 32'(vecs[i].exp_out));
    end

    // Blink: 4 cycles high, 4 low, starting one cycle after the divider write.
    step(0, 0, 3'd0, 0);
    step(1, 1, 3'd0, 32'h7);
    step(1, 1, 3'd1, 32'h1);
    step(1, 1, 3'd2, 32'h3);
    for (int j = 0; j < 16; j++) begin
      step(1, 0, 3'd0, 0);
      chk($sformatf("blink_c%0d", j), 32'(out_port), {29'd0, 2'b11, ((j / 4) % 2) == 0});
    end

    // PWM duty: high-cycle counts over one full 256-cycle period.
    step(0, 0, 3'd0, 0);
    step(1, 1, 3'd0, 32'h1);
    step(1, 1, 3'd3, 32'd64);
    cnt = 0;
    repeat (256) begin step(1, 0, 3'd6, 0); cnt += int'(out_port[0]); end
    chk("pwm64_high_cycles", 32'(cnt), 32'd64);
    step(1, 1, 3'd3, 32'd0);
    cnt = 0;
    repeat (256) begin step(1, 0, 3'd0, 0); cnt += int'(out_port[0]); end
    chk("pwm0_high_cycles", 32'(cnt), 32'd0);
    step(1, 1, 3'd3, 32'd255);
    cnt = 0;
    repeat (256) begin step(1, 0, 3'd0, 0); cnt += int'(out_port[0]); end
    chk("pwm255_high_cycles", 32'(cnt), 32'd256);

    // Reset mid-blink, coincident with a write.
    step(1, 1, 3'd0, 32'h7);
    step(1, 1, 3'd1, 32'h7);
    step(1, 1, 3'd2, 32'h2);
    repeat (4) step(1, 0, 3'd0, 0);
    step(0, 1, 3'd6, 32'h7);
    chk("midrst_status", bus.readdata, 32'h1);
    chk("midrst_out", 32'(out_port), 32'h0);
    step(1, 0, 3'd1, 0);
    chk("midrst_mode", bus.readdata, 32'h0);
    chk("midrst_out_rv", 32'(out_port), 32'(RV));

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      ra  = 3'($urandom_range(0, 7));
      rwd = $urandom;
      if (ra == 3'd2) rwd = 32'($urandom_range(0, 6));
      if (ra == 3'd3) begin
        case ($urandom_range(0, 3))
          0:       rwd = 32'h0;
          1:       rwd = 32'hFF;
          default: rwd = $urandom;
        endcase
      end
      if ($urandom_range(0, 99) < 3)
        step(0, $urandom_range(0, 1) == 1, ra, rwd);
      else
        step(1, $urandom_range(0, 99) < 35, ra, rwd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
